// File: rtl/video_wr_packer.sv
// ---------------------------------------------------------------------------
// video_wr_packer
//
// Packs a 16-bit RGB565 pixel stream into 256-bit DDR words, tags each word
// with an address inside one of two frame buffers, queues the words in a
// small FIFO and hands them one at a time to the DDR AXI write controller
// through its wr_req / wr_busy / wr_done user interface.
// Everything runs in the clk_100M domain.
//
// Ports:
//   clk_100M    in   clock
//   rstn        in   synchronous, active-low reset
//   init_done   in   DDR calibration complete; no requests are issued before
//   pix_vs      in   frame sync level, rising edge starts a new frame
//   pix_valid   in   pixel qualifier
//   pix_data    in   PIX_W-bit pixel
//   wr_req      out  write request level to the controller
//   wr_addr     out  write address, stable while wr_req is high
//   awlen       out  burst length, always 0 (single beat)
//   wr_data     out  write word, stable while wr_req is high
//   wr_busy     in   controller accepted the request
//   wr_done     in   controller finished the write (one-cycle pulse)
//   frame_buf   out  index of the frame buffer currently being filled
//   frame_done  out  one-cycle pulse when the previous frame is fully handed off
//   fifo_ovf    out  sticky: a packed word was dropped on a full FIFO
//   frame_ovf   out  sticky: pixels beyond FRAME_WORDS words were dropped
// ---------------------------------------------------------------------------
module video_wr_packer #(
   parameter int                ADDR_W      = 28,
   parameter int                DATA_W      = 256,
   parameter int                PIX_W       = 16,
   parameter int                FIFO_DEPTH  = 4,
   parameter int                FRAME_WORDS = 30000,
   parameter int                ADDR_STEP   = 8,
   parameter logic [ADDR_W-1:0] BASE0       = 28'h000_0000,
   parameter logic [ADDR_W-1:0] BASE1       = 28'h010_0000
) (
   input  logic              clk_100M,
   input  logic              rstn,
   input  logic              init_done,
   input  logic              pix_vs,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_data,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [3:0]        awlen,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_busy,
   input  logic              wr_done,
   output logic              frame_buf,
   output logic              frame_done,
   output logic              fifo_ovf,
   output logic              frame_ovf
);

   localparam int PIX_PER_WORD = DATA_W / PIX_W;
   localparam int CNT_W        = $clog2(PIX_PER_WORD);
   localparam int IDX_W        = $clog2(FRAME_WORDS + 1);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(PIX_PER_WORD - 1);
   localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(FRAME_WORDS);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_WORDS - 1);
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   // Frame sync edge detection and frame bookkeeping
   logic              vsPrev_q;
   logic              vsRise;
   logic              firstFrame_q, firstFrame_d;
   logic              frameBuf_q, frameBuf_d;

   // Pixel packing
   logic [CNT_W-1:0]  pixCount_q, pixCount_d;
   logic [DATA_W-1:0] wordBuf_q, wordBuf_d;
   logic [IDX_W-1:0]  wordIdx_q, wordIdx_d;
   logic [CNT_W-1:0]  curCount;
   logic [IDX_W-1:0]  curIdx;
   logic              curBuf;
   logic [DATA_W-1:0] assembled;

   // Completed word waiting for its FIFO write slot
   logic              pushValid_q, pushValid_d;
   logic [DATA_W-1:0] pushData_q, pushData_d;
   logic [ADDR_W-1:0] pushAddr_q, pushAddr_d;
   logic              pushLast_q, pushLast_d;

   // Packed-word FIFO
   logic [ADDR_W-1:0] fifoAddr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifoData_q [FIFO_DEPTH];
   logic              fifoLast_q [FIFO_DEPTH];
   logic [PTR_W:0]    wrPtr_q, rdPtr_q;
   logic [PTR_W-1:0]  wrIdx, rdIdx;
   logic              fifoFull, fifoEmpty;
   logic              fifoPush, fifoPop, pushDrop;

   // Status flags
   logic              fifoOvf_q, fifoOvf_d;
   logic              frameOvf_q, frameOvf_d;
   logic              lastDropped_q, lastDropped_d;
   logic              frameDone_q, frameDone_d;

   // Requester
   state_t            state_q, state_d;
   logic              wrReq_q, wrReq_d;
   logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
   logic [DATA_W-1:0] wrData_q, wrData_d;
   logic              curLast_q, curLast_d;

   assign vsRise    = pix_vs & ~vsPrev_q;

   assign wrIdx     = wrPtr_q[PTR_W-1:0];
   assign rdIdx     = rdPtr_q[PTR_W-1:0];
   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) && (wrIdx == rdIdx);

   // Pixel packing. A frame start takes effect in the same cycle it is
   // detected, so a pixel arriving alongside the edge becomes pixel 0 of
   // word 0 of the new frame. The address of a finished word is resolved
   // here, at completion time, so a frame start in the following cycle
   // cannot move it to the wrong buffer.
   always_comb begin
      firstFrame_d = firstFrame_q;
      frameBuf_d   = frameBuf_q;
      pixCount_d   = pixCount_q;
      wordBuf_d    = wordBuf_q;
      wordIdx_d    = wordIdx_q;
      pushValid_d  = 1'b0;
      pushData_d   = pushData_q;
      pushAddr_d   = pushAddr_q;
      pushLast_d   = pushLast_q;
      frameOvf_d   = frameOvf_q;
      curCount     = pixCount_q;
      curIdx       = wordIdx_q;
      curBuf       = frameBuf_q;
      assembled    = wordBuf_q;

      if (vsRise) begin
         curCount     = '0;
         curIdx       = '0;
         if (!firstFrame_q) begin
            curBuf = ~frameBuf_q;
         end
         firstFrame_d = 1'b0;
         frameBuf_d   = curBuf;
         pixCount_d   = '0;
         wordIdx_d    = '0;
      end

      if (pix_valid) begin
         assembled[int'(curCount) * PIX_W +: PIX_W] = pix_data;
         wordBuf_d = assembled;
         if (curCount == LAST_SLOT) begin
            pixCount_d = '0;
            if (curIdx == IDX_FULL) begin
               frameOvf_d = 1'b1;
            end else begin
               pushValid_d = 1'b1;
               pushData_d  = assembled;
               pushAddr_d  = (curBuf ? BASE1 : BASE0) + ADDR_W'(curIdx) * STEP;
               pushLast_d  = (curIdx == IDX_LAST);
               wordIdx_d   = curIdx + IDX_W'(1);
            end
         end else begin
            pixCount_d = curCount + CNT_W'(1);
         end
      end
   end

   // FIFO write side and status flags. A push on a full FIFO is only an
   // overflow if the requester is not popping in the same cycle. If the
   // dropped word was the last of its frame, the controller will never
   // report it, so frame_done is produced on the next frame start instead.
   always_comb begin
      fifoPush      = 1'b0;
      pushDrop      = 1'b0;
      fifoOvf_d     = fifoOvf_q;
      lastDropped_d = lastDropped_q;
      frameDone_d   = 1'b0;

      if (pushValid_q) begin
         if (!fifoFull || fifoPop) begin
            fifoPush = 1'b1;
         end else begin
            pushDrop  = 1'b1;
            fifoOvf_d = 1'b1;
         end
      end

      if (pushDrop && pushLast_q) begin
         lastDropped_d = 1'b1;
      end

      if (state_q == S_WAIT && wr_done && curLast_q) begin
         frameDone_d = 1'b1;
      end

      if (vsRise) begin
         if (lastDropped_q || (pushDrop && pushLast_q)) begin
            frameDone_d = 1'b1;
         end
         lastDropped_d = 1'b0;
      end
   end

   // Requester next-state logic. The word is loaded into the output
   // registers in the same edge that raises wr_req, so address and data are
   // already valid when the controller sees the rising edge. The WAIT state
   // plus one IDLE cycle keeps wr_req low for at least two cycles.
   always_comb begin
      state_d   = state_q;
      wrReq_d   = wrReq_q;
      wrAddr_d  = wrAddr_q;
      wrData_d  = wrData_q;
      curLast_d = curLast_q;
      fifoPop   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifoEmpty && init_done) begin
               fifoPop   = 1'b1;
               wrReq_d   = 1'b1;
               wrAddr_d  = fifoAddr_q[rdIdx];
               wrData_d  = fifoData_q[rdIdx];
               curLast_d = fifoLast_q[rdIdx];
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            if (wr_busy) begin
               wrReq_d = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wr_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            wrReq_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO storage. Entries need no reset: the pointers decide what is valid.
   always_ff @(posedge clk_100M) begin
      if (fifoPush) begin
         fifoAddr_q[wrIdx] <= pushAddr_q;
         fifoData_q[wrIdx] <= pushData_q;
         fifoLast_q[wrIdx] <= pushLast_q;
      end
   end

   // All control and datapath registers. Reset discards the FIFO contents,
   // any partial word and any in-flight controller transaction.
   always_ff @(posedge clk_100M) begin
      if (!rstn) begin
         vsPrev_q      <= 1'b0;
         firstFrame_q  <= 1'b1;
         frameBuf_q    <= 1'b0;
         pixCount_q    <= '0;
         wordBuf_q     <= '0;
         wordIdx_q     <= '0;
         pushValid_q   <= 1'b0;
         pushData_q    <= '0;
         pushAddr_q    <= '0;
         pushLast_q    <= 1'b0;
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         fifoOvf_q     <= 1'b0;
         frameOvf_q    <= 1'b0;
         lastDropped_q <= 1'b0;
         frameDone_q   <= 1'b0;
         state_q       <= S_IDLE;
         wrReq_q       <= 1'b0;
         wrAddr_q      <= '0;
         wrData_q      <= '0;
         curLast_q     <= 1'b0;
      end else begin
         vsPrev_q      <= pix_vs;
         firstFrame_q  <= firstFrame_d;
         frameBuf_q    <= frameBuf_d;
         pixCount_q    <= pixCount_d;
         wordBuf_q     <= wordBuf_d;
         wordIdx_q     <= wordIdx_d;
         pushValid_q   <= pushValid_d;
         pushData_q    <= pushData_d;
         pushAddr_q    <= pushAddr_d;
         pushLast_q    <= pushLast_d;
         wrPtr_q       <= wrPtr_q + (PTR_W+1)'(fifoPush);
         rdPtr_q       <= rdPtr_q + (PTR_W+1)'(fifoPop);
         fifoOvf_q     <= fifoOvf_d;
         frameOvf_q    <= frameOvf_d;
         lastDropped_q <= lastDropped_d;
         frameDone_q   <= frameDone_d;
         state_q       <= state_d;
         wrReq_q       <= wrReq_d;
         wrAddr_q      <= wrAddr_d;
         wrData_q      <= wrData_d;
         curLast_q     <= curLast_d;
      end
   end

   assign wr_req     = wrReq_q;
   assign wr_addr    = wrAddr_q;
   assign wr_data    = wrData_q;
   assign awlen      = 4'd0;
   assign frame_buf  = frameBuf_q;
   assign frame_done = frameDone_q;
   assign fifo_ovf   = fifoOvf_q;
   assign frame_ovf  = frameOvf_q;

endmodule

// File: tb/tb_video_wr_packer.sv
// ---------------------------------------------------------------------------
// tb_video_wr_packer
//
// Directed bench for video_wr_packer. Two instances share the pixel inputs:
// index 0 uses the full-size frame, index 1 a two-word frame for the frame
// overflow / frame_done case. Each instance gets its own small controller
// model (busy 2 cycles after the wr_req rise, done 4 cycles after that).
// ---------------------------------------------------------------------------
module tb_video_wr_packer;

   localparam int AW = 28;
   localparam int DW = 256;
   localparam logic [AW-1:0] BASE1 = 28'h010_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn = 1'b0;
   logic          initDone = 1'b0;
   logic          pixVs = 1'b0;
   logic          pixValid = 1'b0;
   logic [15:0]   pixData = '0;
   logic [1:0]    wrBusy;
   logic [1:0]    wrDone;

   wire  [1:0]    wrReq, frameBuf, frameDone, fifoOvf, frameOvf;
   wire  [3:0]    awlen  [2];
   wire  [AW-1:0] wrAddr [2];
   wire  [DW-1:0] wrData [2];

   // Controller model and monitor state, one slot per instance
   int            reqCnt [2];
   int            doneCnt [2];
   int            fdCnt [2];
   int            fdAtDone [2];
   int            minGap [2];
   int            lowRun [2];
   int            stabErr [2];
   int            mState [2];
   int            mCnt [2];
   logic          prevReq [2];
   logic [AW-1:0] holdAddr [2];
   logic [DW-1:0] holdData [2];
   logic [AW-1:0] addrLog [2][16];
   logic [DW-1:0] dataLog [2][16];

   int            vecCount = 0;
   int            missCount = 0;

   video_wr_packer dut (
      .clk_100M   (clk),
      .rstn       (rstn),
      .init_done  (initDone),
      .pix_vs     (pixVs),
      .pix_valid  (pixValid),
      .pix_data   (pixData),
      .wr_req     (wrReq[0]),
      .wr_addr    (wrAddr[0]),
      .awlen      (awlen[0]),
      .wr_data    (wrData[0]),
      .wr_busy    (wrBusy[0]),
      .wr_done    (wrDone[0]),
      .frame_buf  (frameBuf[0]),
      .frame_done (frameDone[0]),
      .fifo_ovf   (fifoOvf[0]),
      .frame_ovf  (frameOvf[0])
   );

   video_wr_packer #(.FRAME_WORDS(2)) dutSmall (
      .clk_100M   (clk),
      .rstn       (rstn),
      .init_done  (initDone),
      .pix_vs     (pixVs),
      .pix_valid  (pixValid),
      .pix_data   (pixData),
      .wr_req     (wrReq[1]),
      .wr_addr    (wrAddr[1]),
      .awlen      (awlen[1]),
      .wr_data    (wrData[1]),
      .wr_busy    (wrBusy[1]),
      .wr_done    (wrDone[1]),
      .frame_buf  (frameBuf[1]),
      .frame_done (frameDone[1]),
      .fifo_ovf   (fifoOvf[1]),
      .frame_ovf  (frameOvf[1])
   );

   // Monitor and controller model, evaluated on the falling edge so DUT
   // outputs are stable and model inputs change away from the active edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rstn) begin
            mState[i]  = 0;
            mCnt[i]    = 0;
            wrBusy[i]  = 1'b0;
            wrDone[i]  = 1'b0;
            prevReq[i] = 1'b0;
         end else begin
            wrDone[i] = 1'b0;
            if (wrReq[i] && !prevReq[i]) begin
               if (reqCnt[i] < 16) begin
                  addrLog[i][reqCnt[i]] = wrAddr[i];
                  dataLog[i][reqCnt[i]] = wrData[i];
               end
               if (reqCnt[i] > 0 && lowRun[i] < minGap[i]) minGap[i] = lowRun[i];
               reqCnt[i]++;
               holdAddr[i] = wrAddr[i];
               holdData[i] = wrData[i];
            end else if (wrReq[i] && (wrAddr[i] !== holdAddr[i] || wrData[i] !== holdData[i])) begin
               stabErr[i]++;
            end
            if (wrReq[i]) lowRun[i] = 0;
            else lowRun[i]++;
            if (frameDone[i]) begin
               fdCnt[i]++;
               fdAtDone[i] = doneCnt[i];
            end
            case (mState[i])
               0: if (wrReq[i] && !prevReq[i]) begin
                     mState[i] = 1;
                     mCnt[i]   = 0;
                  end
               1: begin
                     mCnt[i]++;
                     if (mCnt[i] == 2) begin
                        wrBusy[i] = 1'b1;
                        mState[i] = 2;
                        mCnt[i]   = 0;
                     end
                  end
               2: begin
                     mCnt[i]++;
                     if (mCnt[i] == 4) begin
                        wrBusy[i] = 1'b0;
                        wrDone[i] = 1'b1;
                        doneCnt[i]++;
                        mState[i] = 0;
                     end
                  end
               default: mState[i] = 0;
            endcase
            prevReq[i] = wrReq[i];
         end
      end
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Expected packed word when pixel k carries the value first+k
   function automatic logic [DW-1:0] makeWord(input int first);
      logic [DW-1:0] w;
      w = '0;
      for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'(first + k);
      return w;
   endfunction

   task automatic clearLogs();
      for (int i = 0; i < 2; i++) begin
         reqCnt[i]   = 0;
         doneCnt[i]  = 0;
         fdCnt[i]    = 0;
         fdAtDone[i] = 0;
         minGap[i]   = 1000;
         lowRun[i]   = 0;
         stabErr[i]  = 0;
      end
   endtask

   // Reset both instances, verify reset values, release and clear the logs
   task automatic applyReset(input string tag);
      rstn     = 1'b0;
      pixValid = 1'b0;
      pixVs    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput({tag, "_rst_req"},   wrReq[0], 0);
      checkOutput({tag, "_rst_addr"},  wrAddr[0], 0);
      checkOutput({tag, "_rst_data"},  wrData[0], 0);
      checkOutput({tag, "_rst_flags"}, {frameBuf[0], frameDone[0], fifoOvf[0], frameOvf[0]}, 0);
      rstn = 1'b1;
      clearLogs();
      @(negedge clk);
   endtask

   // Drive n consecutive pixels first, first+1, ... one per clock
   task automatic applyStimulus(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         pixValid = 1'b1;
         pixData  = 16'(first + i);
         @(negedge clk);
      end
      pixValid = 1'b0;
   endtask

   task automatic pulseVs();
      pixVs = 1'b1;
      repeat (2) @(negedge clk);
      pixVs = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int waited;
      int reqBase;
      clearLogs();

      // Single word
      initDone = 1'b1;
      applyReset("t1");
      applyStimulus(0, 16);
      repeat (40) @(negedge clk);
      checkOutput("t1_req_count", reqCnt[0], 1);
      checkOutput("t1_addr",      addrLog[0][0], 0);
      checkOutput("t1_pix0",      dataLog[0][0][15:0], 16'h0000);
      checkOutput("t1_pix15",     dataLog[0][0][255:240], 16'h000F);
      checkOutput("t1_word",      dataLog[0][0], makeWord(0));
      checkOutput("t1_awlen",     awlen[0], 0);

      // Three back-to-back words
      applyReset("t2");
      applyStimulus(16'h100, 48);
      repeat (80) @(negedge clk);
      checkOutput("t2_req_count", reqCnt[0], 3);
      checkOutput("t2_addr0",     addrLog[0][0], 28'h0);
      checkOutput("t2_addr1",     addrLog[0][1], 28'h8);
      checkOutput("t2_addr2",     addrLog[0][2], 28'h10);
      checkOutput("t2_word1",     dataLog[0][1], makeWord(16'h110));
      checkOutput("t2_gap_ge2",   (minGap[0] >= 2), 1);
      checkOutput("t2_stable",    stabErr[0], 0);

      // Calibration pending: FIFO fills and overflows, then drains
      initDone = 1'b0;
      applyReset("t3");
      applyStimulus(0, 64);
      repeat (3) @(negedge clk);
      checkOutput("t3_ovf_at4",   fifoOvf[0], 0);
      applyStimulus(64, 16);
      repeat (3) @(negedge clk);
      checkOutput("t3_ovf_at5",   fifoOvf[0], 1);
      checkOutput("t3_no_req",    reqCnt[0], 0);
      initDone = 1'b1;
      repeat (80) @(negedge clk);
      checkOutput("t3_req_count", reqCnt[0], 4);
      checkOutput("t3_addr0",     addrLog[0][0], 28'h0);
      checkOutput("t3_addr3",     addrLog[0][3], 28'h18);
      checkOutput("t3_word3",     dataLog[0][3], makeWord(48));

      // Frame start mid-word: partial discarded, next frame in buffer 1
      applyReset("t4");
      pulseVs();
      checkOutput("t4_buf_first", frameBuf[0], 0);
      applyStimulus(16'h100, 24);
      pulseVs();
      checkOutput("t4_buf_second", frameBuf[0], 1);
      applyStimulus(16'h200, 16);
      repeat (60) @(negedge clk);
      checkOutput("t4_req_count", reqCnt[0], 2);
      checkOutput("t4_addr0",     addrLog[0][0], 28'h0);
      checkOutput("t4_word0",     dataLog[0][0], makeWord(16'h100));
      checkOutput("t4_addr1",     addrLog[0][1], BASE1);
      checkOutput("t4_word1",     dataLog[0][1], makeWord(16'h200));

      // Two-word frame on the small instance
      applyReset("t5");
      applyStimulus(0, 32);
      repeat (3) @(negedge clk);
      checkOutput("t5_frame_ovf_pre", frameOvf[1], 0);
      applyStimulus(32, 16);
      repeat (3) @(negedge clk);
      checkOutput("t5_frame_ovf",  frameOvf[1], 1);
      repeat (60) @(negedge clk);
      checkOutput("t5_req_count",  reqCnt[1], 2);
      checkOutput("t5_addr1",      addrLog[1][1], 28'h8);
      checkOutput("t5_fd_count",   fdCnt[1], 1);
      checkOutput("t5_fd_after2",  fdAtDone[1], 2);
      checkOutput("t5_big_no_fovf", frameOvf[0], 0);
      checkOutput("t5_big_no_fd",  fdCnt[0], 0);

      // Reset while a request is outstanding with another word queued
      initDone = 1'b0;
      applyReset("t6");
      applyStimulus(0, 32);
      repeat (3) @(negedge clk);
      initDone = 1'b1;
      waited = 0;
      while (!wrReq[0] && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("t6_req_seen", wrReq[0], 1);
      rstn = 1'b0;
      @(negedge clk);
      checkOutput("t6_req_dropped", wrReq[0], 0);
      checkOutput("t6_addr_clr",    wrAddr[0], 0);
      rstn = 1'b1;
      reqBase = reqCnt[0];
      repeat (60) @(negedge clk);
      checkOutput("t6_no_new_req",  reqCnt[0], reqBase);
      checkOutput("t6_req_low",     wrReq[0], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
